resp_checker: RTL and testbench

Synthesizable response checker: the consuming end of the stimulus/compare flow used by our circuit benches. Each valid cycle it takes a reference output vector and a DUT output vector, and keeps sample and mismatch counts, the first-mismatch sample index, and a sticky per-bit error mask. It runs as a small run/stop state machine, so it can sit on-chip next to a stimulus generator and report pass/fail without a simulator.

---
 rtl/resp_checker_if.sv | 32 +++
 rtl/resp_checker.sv | 112 +++++++++++
 tb/tb_resp_checker.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/resp_checker_if.sv
// Bus bundle between a stimulus/compare source and the response checker.
interface resp_checker_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 32
);
  logic             start;
  logic             stop;
  logic             sample_valid;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] dut_q;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] samples;
  logic [CNT_W-1:0] errors;
  logic [CNT_W-1:0] first_err_idx;
  logic             first_err_seen;
  logic [WIDTH-1:0] err_mask;
  logic             mismatch;
  logic             pass;

  modport master (
    output start, stop, sample_valid, ref_q, dut_q,
    input  busy, done, samples, errors, first_err_idx, first_err_seen,
           err_mask, mismatch, pass
  );

  modport slave (
    input  start, stop, sample_valid, ref_q, dut_q,
    output busy, done, samples, errors, first_err_idx, first_err_seen,
           err_mask, mismatch, pass
  );
endinterface

// File: rtl/resp_checker.sv
// Response checker: counts samples and mismatches between reference and DUT
// vectors during a run, with first-mismatch index and sticky per-bit mask.
module resp_checker #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MAX_SAMPLES = 200
) (
  input  logic           clk,
  input  logic           rst_n,
  resp_checker_if.slave  bus
);

  localparam bit               LIMIT_EN  = (MAX_SAMPLES != 0);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] samples_q;
  logic [CNT_W-1:0] errors_q;
  logic [CNT_W-1:0] first_idx_q;
  logic             seen_q;
  logic [WIDTH-1:0] mask_q;
  logic             mismatch_q;

  logic [WIDTH-1:0] diff;
  logic             any_diff;
  logic             accept;
  logic [CNT_W-1:0] samples_d;
  logic [CNT_W-1:0] errors_d;
  logic             limit_hit;

  // Per-sample datapath: difference vector and saturating counter increments.
  always_comb begin
    diff      = bus.ref_q ^ bus.dut_q;
    any_diff  = |diff;
    accept    = (state_q == ST_RUN) && bus.sample_valid;
    samples_d = (&samples_q) ? samples_q : samples_q + CNT_ONE;
    errors_d  = (&errors_q)  ? errors_q  : errors_q + CNT_ONE;
    limit_hit = LIMIT_EN && (samples_d == MAX_C);
  end

  // Run/stop FSM with registered status outputs and run statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      samples_q   <= '0;
      errors_q    <= '0;
      first_idx_q <= '0;
      seen_q      <= 1'b0;
      mask_q      <= '0;
      mismatch_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            samples_q  <= samples_d;
            mask_q     <= mask_q | diff;
            mismatch_q <= any_diff;
            if (any_diff) begin
              errors_q <= errors_d;
            end
            if (any_diff && !seen_q) begin
              first_idx_q <= samples_q;
              seen_q      <= 1'b1;
            end
          end
          // A sample arriving with stop is still counted before ending.
          if (bus.stop || (accept && limit_hit)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE: start (which wins over stop) clears and runs.
          if (bus.start) begin
            state_q     <= ST_RUN;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            samples_q   <= '0;
            errors_q    <= '0;
            first_idx_q <= '0;
            seen_q      <= 1'b0;
            mask_q      <= '0;
            mismatch_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.samples        = samples_q;
  assign bus.errors         = errors_q;
  assign bus.first_err_idx  = first_idx_q;
  assign bus.first_err_seen = seen_q;
  assign bus.err_mask       = mask_q;
  assign bus.mismatch       = mismatch_q;
  assign bus.pass           = done_q & ~seen_q;

endmodule

// File: tb/tb_resp_checker.sv
// Bench for resp_checker: two instances (4-bit/32-bit counters/limit 10 and
// 1-bit/4-bit counters/unlimited) checked every cycle against a run model.
module tb_resp_checker;

  logic clk;
  logic rst_n;

  int unsigned n_checks;
  int unsigned n_errors;

  resp_checker_if #(.WIDTH(4), .CNT_W(32)) if4 ();
  resp_checker_if #(.WIDTH(1), .CNT_W(4))  if1 ();

  resp_checker #(.WIDTH(4), .CNT_W(32), .MAX_SAMPLES(10)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  resp_checker #(.WIDTH(1), .CNT_W(4), .MAX_SAMPLES(0)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus; the 1-bit instance sees bit 0 of each vector.
  logic       st, sp, sv;
  logic [3:0] rv, dv;

  assign if4.start = st;  assign if1.start = st;
  assign if4.stop  = sp;  assign if1.stop  = sp;
  assign if4.sample_valid = sv;  assign if1.sample_valid = sv;
  assign if4.ref_q = rv;  assign if1.ref_q = rv[0];
  assign if4.dut_q = dv;  assign if1.dut_q = dv[0];

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] samples;
    logic [31:0] errors;
    logic [31:0] idx;
    logic        seen;
    logic [3:0]  mask;
    logic        mism;
    logic        run;
    logic        done;
  } mstate_t;

  mstate_t m4, m1;

  function automatic logic [31:0] sat_inc(logic [31:0] v, logic [31:0] cmax);
    return (v >= cmax) ? cmax : v + 32'd1;
  endfunction

  function automatic mstate_t step(mstate_t m, logic s_start, logic s_stop,
                                   logic s_valid, logic [3:0] r, logic [3:0] d,
                                   logic [31:0] cmax, logic [31:0] smax,
                                   logic [3:0] wm);
    mstate_t    n;
    logic [3:0] df;
    n  = m;
    df = (r ^ d) & wm;
    if (m.run) begin
      if (s_valid) begin
        if (df != 4'd0 && !m.seen) begin
          n.idx  = m.samples;
          n.seen = 1'b1;
        end
        n.samples = sat_inc(m.samples, cmax);
        if (df != 4'd0) n.errors = sat_inc(m.errors, cmax);
        n.mask = m.mask | df;
        n.mism = (df != 4'd0);
      end
      if (s_stop || (s_valid && smax != 0 && n.samples == smax)) begin
        n.run  = 1'b0;
        n.done = 1'b1;
      end
    end else if (s_start) begin
      n      = '0;
      n.run  = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4 <= '0;
      m1 <= '0;
    end else begin
      m4 <= step(m4, st, sp, sv, rv, dv, 32'hFFFF_FFFF, 32'd10, 4'hF);
      m1 <= step(m1, st, sp, sv, rv, dv, 32'd15,        32'd0,  4'h1);
    end
  end

  // ---------------- comparison ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, both instances against the model.
  always @(negedge clk) begin
    check("d4.busy",     32'(if4.busy),           32'(m4.run));
    check("d4.done",     32'(if4.done),           32'(m4.done));
    check("d4.samples",  if4.samples,             m4.samples);
    check("d4.errors",   if4.errors,              m4.errors);
    check("d4.first_idx",if4.first_err_idx,       m4.idx);
    check("d4.seen",     32'(if4.first_err_seen), 32'(m4.seen));
    check("d4.mask",     32'(if4.err_mask),       32'(m4.mask));
    check("d4.mismatch", 32'(if4.mismatch),       32'(m4.mism));
    check("d4.pass",     32'(if4.pass),           32'(m4.done & ~m4.seen));
    check("d1.busy",     32'(if1.busy),           32'(m1.run));
    check("d1.done",     32'(if1.done),           32'(m1.done));
    check("d1.samples",  32'(if1.samples),        m1.samples);
    check("d1.errors",   32'(if1.errors),         m1.errors);
    check("d1.first_idx",32'(if1.first_err_idx),  m1.idx);
    check("d1.seen",     32'(if1.first_err_seen), 32'(m1.seen));
    check("d1.mask",     32'(if1.err_mask),       32'(m1.mask));
    check("d1.mismatch", 32'(if1.mismatch),       32'(m1.mism));
    check("d1.pass",     32'(if1.pass),           32'(m1.done & ~m1.seen));
  end

  // Drive one cycle of inputs at the falling edge.
  task automatic cyc(input logic a_st, input logic a_sp, input logic a_sv,
                     input logic [3:0] a_r, input logic [3:0] a_d);
    @(negedge clk);
    st = a_st; sp = a_sp; sv = a_sv; rv = a_r; dv = a_d;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    st = 1'b0; sp = 1'b0; sv = 1'b0; rv = 4'h0; dv = 4'h0;
    idle(); idle();
    rst_n = 1'b1;
    idle();
    check("lit.reset_samples", if4.samples, 32'd0);
    check("lit.reset_busy",    32'(if4.busy), 32'd0);

    // Samples with no start are ignored.
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 4'h5, 4'hA);
    idle();
    check("lit.idle_samples", if4.samples, 32'd0);
    check("lit.idle_errors",  if4.errors,  32'd0);
    check("lit.idle_done",    32'(if4.done), 32'd0);

    // Clean run of 10 matching samples: auto-done on the 10th.
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 4'(i), 4'(i));
    idle();
    check("lit.clean_done",    32'(if4.done),     32'd1);
    check("lit.clean_samples", if4.samples,       32'd10);
    check("lit.clean_pass",    32'(if4.pass),     32'd1);
    check("lit.clean_mask",    32'(if4.err_mask), 32'd0);

    // Errors on 0-based samples 3 (bit 0) and 7 (bit 3).
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      logic [3:0] d;
      d = 4'h6;
      if (i == 3) d = 4'h7;
      if (i == 7) d = 4'hE;
      cyc(1'b0, 1'b0, 1'b1, 4'h6, d);
      if (i == 4) check("lit.mismatch_after3", 32'(if4.mismatch), 32'd1);
      if (i == 5) check("lit.mismatch_after4", 32'(if4.mismatch), 32'd0);
    end
    idle();
    check("lit.err_errors", if4.errors,              32'd2);
    check("lit.err_idx",    if4.first_err_idx,       32'd3);
    check("lit.err_seen",   32'(if4.first_err_seen), 32'd1);
    check("lit.err_pass",   32'(if4.pass),           32'd0);
    check("lit.err_mask",   32'(if4.err_mask),       32'h9);

    // Early stop with the 5th sample; restart with start+stop together.
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 4'h3, 4'h3);
    cyc(1'b0, 1'b1, 1'b1, 4'h3, 4'h3);
    idle();
    check("lit.stop_samples", if4.samples,   32'd5);
    check("lit.stop_done",    32'(if4.done), 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    idle();
    check("lit.restart_busy",    32'(if4.busy), 32'd1);
    check("lit.restart_samples", if4.samples,   32'd0);

    // Start mid-run is ignored; then async reset after 4 samples.
    cyc(1'b0, 1'b0, 1'b1, 4'h1, 4'h0);
    cyc(1'b1, 1'b0, 1'b1, 4'h1, 4'h1);
    cyc(1'b0, 1'b0, 1'b1, 4'h2, 4'h2);
    cyc(1'b0, 1'b0, 1'b1, 4'h2, 4'h0);
    idle();
    check("lit.pre_reset_samples", if4.samples, 32'd4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("lit.async_samples", if4.samples,     32'd0);
    check("lit.async_busy",    32'(if4.busy),   32'd0);
    check("lit.async_mask",    32'(if4.err_mask), 32'd0);
    idle();
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 4'hF, 4'h0);
    idle();
    check("lit.post_reset_samples", if4.samples, 32'd0);
    check("lit.post_reset_busy",    32'(if4.busy), 32'd0);

    // 20 mismatching samples: the 4-bit counters of the 1-bit instance saturate.
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b1, 4'h1, 4'h0);
    idle();
    check("lit.sat_samples", 32'(if1.samples), 32'd15);
    check("lit.sat_errors",  32'(if1.errors),  32'd15);
    check("lit.sat_busy",    32'(if1.busy),    32'd1);
    check("lit.lim_samples", if4.samples,      32'd10);
    cyc(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    idle();
    check("lit.sat_done", 32'(if1.done), 32'd1);
    check("lit.sat_pass", 32'(if1.pass), 32'd0);
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
